// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory handshake,
// and presents one instruction (or a bubble) per cycle to the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ready,
    input  logic [31:0] IM_RData,
    input  logic        ID_Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        ExcTake,
    output logic [31:0] Instruction,
    output logic [31:0] PCOut,
    output logic [31:0] PCAdd4,
    output logic        IsBDS,
    output logic        Stall,
    output logic        Flush
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_buf_q, hold_buf_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;

    logic            im_req;
    logic            valid;
    logic            deliver;
    logic            is_bds;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_out;

    // Next-state, next-PC and presentation logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_buf_d    = hold_buf_q;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        im_req        = 1'b0;
        valid         = 1'b0;
        instr         = '0;

        case (state_q)
            ST_FETCH: begin
                im_req = 1'b1;
                valid  = IM_Ready;
                instr  = IM_Ready ? IM_RData : '0;
            end
            ST_HOLD: begin
                valid = 1'b1;
                instr = hold_buf_q;
            end
            ST_DRAIN: begin
                im_req = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        deliver = valid & ~ID_Stall & ~ExcTake;
        is_bds  = deliver & (BranchTaken | pending_q);

        // The abandoned fetch completes independently of any new exception
        if (state_q == ST_DRAIN && IM_Ready) begin
            pc_d    = EXC_VECTOR;
            state_d = ST_FETCH;
        end

        if (ExcTake) begin
            pending_d = 1'b0;
            if (state_q == ST_HOLD) begin
                pc_d    = EXC_VECTOR;
                state_d = ST_FETCH;
            end else if (state_q == ST_FETCH) begin
                if (IM_Ready) begin
                    pc_d = EXC_VECTOR;
                end else begin
                    // Keep the address stable until memory answers
                    state_d = ST_DRAIN;
                end
            end
        end else begin
            if (state_q == ST_FETCH && IM_Ready && ID_Stall) begin
                hold_buf_d = IM_RData;
                state_d    = ST_HOLD;
            end
            if (state_q == ST_HOLD && deliver) begin
                state_d = ST_FETCH;
            end

            if (deliver) begin
                if (BranchTaken) begin
                    pc_d      = BranchTarget;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    pc_d      = pend_target_q;
                    pending_d = 1'b0;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end else if (BranchTaken && !ID_Stall && !valid && state_q != ST_DRAIN) begin
                // Delay slot not yet fetched: remember where to go after it
                pending_d     = 1'b1;
                pend_target_d = BranchTarget;
            end
        end
    end

    // Port drive; reset forces the documented idle values combinationally
    always_comb begin
        pc_out      = RST ? RESET_PC : pc_q;
        IM_Req      = ~RST & im_req;
        IM_Addr     = pc_out;
        Instruction = RST ? '0 : instr;
        PCOut       = pc_out;
        PCAdd4      = pc_out + PC_STEP;
        IsBDS       = ~RST & is_bds;
        Stall       = RST | ~valid;
        Flush       = ~RST & ExcTake;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            hold_buf_q    <= '0;
            pending_q     <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_buf_q    <= hold_buf_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a scoreboard of expected deliveries.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bds;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        IM_Ready;
    logic [31:0] IM_RData;
    logic        ID_Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        ExcTake;

    logic        IM_Req,  w_IM_Req;
    logic [31:0] IM_Addr, w_IM_Addr;
    logic [31:0] Instruction, w_Instruction;
    logic [31:0] PCOut, w_PCOut;
    logic [31:0] PCAdd4, w_PCAdd4;
    logic        IsBDS, w_IsBDS;
    logic        Stall, w_Stall;
    logic        Flush, w_Flush;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];

    if_stage u_dut (
        .CLK(CLK), .RST(RST),
        .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ready(IM_Ready), .IM_RData(IM_RData),
        .ID_Stall(ID_Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ExcTake(ExcTake), .Instruction(Instruction), .PCOut(PCOut), .PCAdd4(PCAdd4),
        .IsBDS(IsBDS), .Stall(Stall), .Flush(Flush)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .EXC_VECTOR(32'h8000_0180)) u_wrap (
        .CLK(CLK), .RST(RST),
        .IM_Req(w_IM_Req), .IM_Addr(w_IM_Addr), .IM_Ready(IM_Ready), .IM_RData(IM_RData),
        .ID_Stall(ID_Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ExcTake(ExcTake), .Instruction(w_Instruction), .PCOut(w_PCOut), .PCAdd4(w_PCAdd4),
        .IsBDS(w_IsBDS), .Stall(w_Stall), .Flush(w_Flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic bds);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.bds   = bds;
        sb.push_back(e);
    endtask

    // One clock: drive after the edge, sample mid-cycle, pop the scoreboard on delivery
    task automatic cyc(input string tag, input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic ids, input logic br, input logic [31:0] bt, input logic exc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                       input logic e_flush);
        exp_t e;
        @(posedge CLK);
        #1;
        RST          = rst;
        IM_Ready     = rdy;
        IM_RData     = rd;
        ID_Stall     = ids;
        BranchTaken  = br;
        BranchTarget = bt;
        ExcTake      = exc;
        @(negedge CLK);
        chk({tag, ".req"}, 32'(IM_Req), 32'(e_req));
        if (e_req) chk({tag, ".addr"}, IM_Addr, e_addr);
        chk({tag, ".stall"}, 32'(Stall), 32'(e_stall));
        chk({tag, ".flush"}, 32'(Flush), 32'(e_flush));
        if (!Stall && !Flush && !ID_Stall) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL %s.unexpected_delivery observed_pc=%h expected=none", tag, PCOut);
            end else begin
                e = sb.pop_front();
                chk({tag, ".pc"}, PCOut, e.pc);
                chk({tag, ".instr"}, Instruction, e.instr);
                chk({tag, ".pcadd4"}, PCAdd4, e.pc + 32'd4);
                chk({tag, ".bds"}, 32'(IsBDS), 32'(e.bds));
            end
        end
    endtask

    task automatic deliver(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic br, input logic [31:0] bt, input logic bds);
        push(addr, data, bds);
        cyc(tag, 1'b0, 1'b1, data, 1'b0, br, bt, 1'b0, 1'b1, addr, 1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rst_isbds"}, 32'(IsBDS), 32'd0);
        chk({tag, ".rst_instr"}, Instruction, 32'd0);
        chk({tag, ".rst_pcout"}, PCOut, 32'hBFC0_0000);
        chk({tag, ".rst_pcadd4"}, PCAdd4, 32'hBFC0_0004);
    endtask

    initial begin
        RST = 1'b1; IM_Ready = 1'b0; IM_RData = '0; ID_Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0; ExcTake = 1'b0;

        // Reset values
        cyc("reset0", 1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0);
        cyc("reset1", 1, 1, 32'h1111_1111, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0);
        chk_reset("reset1");
        chk("wrap.rst_pcadd4", w_PCAdd4, 32'h0);

        // Streaming, with the wrap instance checked alongside
        deliver("stream0", 32'hBFC0_0000, 32'h0000_0A00, 0, 32'h0, 0);
        chk("wrap.addr0", w_IM_Addr, 32'hFFFF_FFFC);
        chk("wrap.pcadd4", w_PCAdd4, 32'h0);
        deliver("stream1", 32'hBFC0_0004, 32'h0000_0A04, 0, 32'h0, 0);
        chk("wrap.addr1", w_IM_Addr, 32'h0);
        deliver("stream2", 32'hBFC0_0008, 32'h0000_0A08, 0, 32'h0, 0);
        deliver("stream3", 32'hBFC0_000C, 32'h0000_0A0C, 0, 32'h0, 0);

        // Wait states keep the address stable
        cyc("wait0", 0, 0, 32'hDEAD_0000, 0, 0, 32'h0, 0, 1, 32'hBFC0_0010, 1, 0);
        cyc("wait1", 0, 0, 32'hDEAD_0001, 0, 0, 32'h0, 0, 1, 32'hBFC0_0010, 1, 0);
        deliver("wait2", 32'hBFC0_0010, 32'h0000_0A10, 0, 32'h0, 0);
        deliver("wait3", 32'hBFC0_0014, 32'h0000_0A14, 0, 32'h0, 0);

        // Downstream stall parks the word in HOLD
        cyc("hold0", 0, 1, 32'h2408_0001, 1, 0, 32'h0, 0, 1, 32'hBFC0_0018, 0, 0);
        cyc("hold1", 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        chk("hold1.instr", Instruction, 32'h2408_0001);
        cyc("hold2", 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        chk("hold2.instr", Instruction, 32'h2408_0001);
        chk("hold2.pcout", PCOut, 32'hBFC0_0018);
        push(32'hBFC0_0018, 32'h2408_0001, 1'b0);
        cyc("hold3", 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        deliver("hold4", 32'hBFC0_001C, 32'h0000_0A1C, 0, 32'h0, 0);

        // Reset while in HOLD
        cyc("hrst0", 0, 1, 32'h2408_0002, 1, 0, 32'h0, 0, 1, 32'hBFC0_0020, 0, 0);
        cyc("hrst1", 1, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 0);
        chk_reset("hrst1");
        deliver("hrst2", 32'hBFC0_0000, 32'h0000_0B00, 0, 32'h0, 0);

        // Branch resolved while its delay slot is delivered
        deliver("br0", 32'hBFC0_0004, 32'h0000_0B04, 1, 32'h8000_0100, 1);
        deliver("br1", 32'h8000_0100, 32'h0000_0C00, 0, 32'h0, 0);

        // Branch resolved while the delay-slot fetch waits
        cyc("brw0", 0, 0, 32'h0, 0, 1, 32'h8000_0200, 0, 1, 32'h8000_0104, 1, 0);
        cyc("brw1", 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h8000_0104, 1, 0);
        deliver("brw2", 32'h8000_0104, 32'h0000_0C04, 0, 32'h0, 1);
        deliver("brw3", 32'h8000_0200, 32'h0000_0D00, 0, 32'h0, 0);

        // Exception during an outstanding fetch drains it first
        cyc("exc0", 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h8000_0204, 1, 1);
        cyc("exc1", 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h8000_0204, 1, 0);
        cyc("exc2", 0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0, 0, 1, 32'h8000_0204, 1, 0);
        deliver("exc3", 32'h8000_0180, 32'h0000_0E00, 0, 32'h0, 0);

        // Exception drops a pending branch redirect
        cyc("excp0", 0, 0, 32'h0, 0, 1, 32'h8000_0300, 0, 1, 32'h8000_0184, 1, 0);
        cyc("excp1", 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h8000_0184, 1, 1);
        cyc("excp2", 0, 1, 32'hBAD1_BAD1, 0, 0, 32'h0, 0, 1, 32'h8000_0184, 1, 0);
        deliver("excp3", 32'h8000_0180, 32'h0000_0E10, 0, 32'h0, 0);
        deliver("excp4", 32'h8000_0184, 32'h0000_0E14, 0, 32'h0, 0);

        // Exception while holding discards the held word
        cyc("exch0", 0, 1, 32'h2408_0003, 1, 0, 32'h0, 0, 1, 32'h8000_0188, 0, 0);
        cyc("exch1", 0, 0, 32'h0, 0, 1, 32'h9000_0000, 1, 0, 32'h0, 0, 1);
        deliver("exch2", 32'h8000_0180, 32'h0000_0E20, 0, 32'h0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
